// File: rtl/dec_ascii_emitter.sv
// dec_ascii_emitter: binary-to-decimal (serial double-dabble) ASCII character streamer, MSD first.
// Define DEC_ASCII_SIGN_EN to treat in_value as two's complement and emit a leading '-'.
module dec_ascii_emitter #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  function automatic int min_digits(input int w);
    logic [63:0] v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++)
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    return n;
  endfunction
  if (WIDTH < 4 || WIDTH > 32 || NDIG < min_digits(WIDTH)) begin : g_bad_params
    $error("dec_ascii_emitter: illegal WIDTH/NDIG combination");
  end
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return d <= 4'd9 ? 8'h30 + {4'h0, d} : 8'h3F;
  endfunction
  typedef enum logic [1:0] {IDLE, CONV, ALIGN, EMIT} state_e;
  state_e            state_q;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     bitcnt_q;
  logic [IW-1:0]     idx_q, hi_idx, nxt_idx;
  logic              out_valid_q, out_last_q;
  logic [7:0]        out_char_q;
`ifdef DEC_ASCII_SIGN_EN
  logic              sign_q;
`endif
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign nxt_idx   = idx_q - IW'(1);
  // One double-dabble step: correct digits >= 5, then shift the whole {bcd,shift} pair.
  always_comb begin
    bcd_adj = bcd_q;
    hi_idx  = '0;
    for (int i = 0; i < NDIG; i++) begin
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      if (bcd_q[4*i +: 4] != 4'd0) hi_idx = IW'(i);
    end
    {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
`ifdef DEC_ASCII_SIGN_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
`ifdef DEC_ASCII_SIGN_EN
          sign_q   <= in_value[WIDTH-1];
          shift_q  <= in_value[WIDTH-1] ? -in_value : in_value;
`else
          shift_q  <= in_value;
`endif
          bcd_q    <= '0;
          bitcnt_q <= '0;
          state_q  <= CONV;
        end
        CONV: begin
          bcd_q    <= bcd_d;
          shift_q  <= shift_d;
          bitcnt_q <= bitcnt_q + CW'(1);
          if (bitcnt_q == CW'(WIDTH - 1)) state_q <= ALIGN;
        end
        ALIGN: begin
          idx_q       <= hi_idx;
          out_valid_q <= 1'b1;
`ifdef DEC_ASCII_SIGN_EN
          out_char_q  <= sign_q ? 8'h2D : to_ascii(bcd_q[4*hi_idx +: 4]);
          out_last_q  <= !sign_q && hi_idx == '0;
`else
          out_char_q  <= to_ascii(bcd_q[4*hi_idx +: 4]);
          out_last_q  <= hi_idx == '0;
`endif
          state_q     <= EMIT;
        end
        EMIT: if (out_ready) begin
          if (out_last_q) begin
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
            state_q     <= IDLE;
`ifdef DEC_ASCII_SIGN_EN
          end else if (sign_q) begin
            sign_q     <= 1'b0;
            out_char_q <= to_ascii(bcd_q[4*idx_q +: 4]);
            out_last_q <= idx_q == '0;
`endif
          end else begin
            idx_q      <= nxt_idx;
            out_char_q <= to_ascii(bcd_q[4*nxt_idx +: 4]);
            out_last_q <= nxt_idx == '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_ascii_emitter.sv
// tb_dec_ascii_emitter: scoreboard bench for dec_ascii_emitter (WIDTH=16, NDIG=5).
// Expected characters are queued at issue time; a negedge monitor pops and compares on each handshake.
module tb_dec_ascii_emitter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_char;
  logic        out_last;
  logic        busy;
  typedef struct {logic [7:0] c; logic l;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit ready_mode = 1'b0;
  bit held_v = 1'b0;
  logic [7:0] held_c;
  logic held_l;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  dec_ascii_emitter #(.WIDTH(16), .NDIG(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_last(out_last), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back('{s[i], i == s.len() - 1});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && q.size() == 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", n < 500, 1);
  endtask
  // Issue one value; check first-character latency and, with out_ready held high, drain length.
  task automatic send(input logic [15:0] v, input string s);
    int n;
    push(s);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_value = 16'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 17);
    chk("busy_in_emit", {busy, in_ready}, 2'b10);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_mode) chk("drain_cycles", n, s.len());
    else chk("drain_done", in_ready, 1);
    chk("sb_empty", q.size(), 0);
  endtask
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      out_ready = ready_mode ? pat[k % 6] : 1'b1;
      k++;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (held_v && out_valid) begin
      chk("stall_char", out_char, held_c);
      chk("stall_last", out_last, held_l);
    end
    held_v = rst_n && out_valid && !out_ready;
    held_c = out_char;
    held_l = out_last;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_char", out_char, 8'hFF);
      else begin
        e = q.pop_front();
        chk("char", out_char, e.c);
        chk("last", out_last, e.l);
      end
    end
  end
  initial begin
    int n;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'd0, "0");
`ifdef DEC_ASCII_SIGN_EN
    send(16'd65535, "-1");
`else
    send(16'd65535, "65535");
`endif
    ready_mode = 1'b1;
    send(16'd1207, "1207");
    send(16'd40, "40");
    ready_mode = 1'b0;
    @(posedge clk); #1;
    push("9");
    push("10");
    in_valid = 1'b1;
    in_value = 16'd9;
    @(posedge clk); #1;
    in_value = 16'd10;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_pending", q.size(), 2);
    @(posedge clk); #1;
    chk("b2b_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_idle();
    push("12345");
    in_valid = 1'b1;
    in_value = 16'd12345;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid_char", out_char, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_ready", in_ready, 1);
    chk("rst_async_busy", busy, 0);
    q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    send(16'd7, "7");
`ifdef DEC_ASCII_SIGN_EN
    send(16'hFFFF, "-1");
    send(16'h8000, "-32768");
    send(16'h7FFF, "32767");
`endif
    repeat (3) @(posedge clk);
    chk("final_sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
